// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fulladder cell processes one bit per clock,
// LSB first. The result appears on sum/cout together with a one-cycle done pulse.

// Single-bit full adder, the only adding logic in the design.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    // $clog2(WIDTH+1) is at least 1 for every legal WIDTH (1..32)
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_load;
    logic             w_busy;
    logic             w_done;
    logic             w_last;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_fa_sum;
    logic             w_fa_cout;
    // Sum shift register contents after the current bit is shifted in
    logic [WIDTH-1:0] w_s_next;

    fulladder u_fa (
        .a   (r_a_sr[0]),
        .b   (r_b_sr[0]),
        .cin (r_carry),
        .sum (w_fa_sum),
        .cout(w_fa_cout)
    );

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // The sum shift register only needs to hold the WIDTH-1 bits already
    // produced; the bit computed this cycle completes it in w_s_next.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_s_next = w_fa_sum;
        end else begin : g_wn
            logic [WIDTH-2:0] r_s_sr;

            // Shift the newly produced sum bit in from the top
            always_ff @(posedge clk) begin
                if (reset)
                    r_s_sr <= '0;
                else if (r_state == RUN)
                    r_s_sr <= w_s_next[WIDTH-1:1];
            end

            assign w_s_next = {w_fa_sum, r_s_sr};
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next-state, operand-load strobe and status outputs
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last)
                    w_next = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                if (start) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand shift, carry and bit counter; result captured on the last bit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_load) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a_sr  <= r_a_sr >> 1;
            r_b_sr  <= r_b_sr >> 1;
            r_carry <= w_fa_cout;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= w_s_next;
                r_cout <= w_fa_cout;
            end
        end
    end

    assign busy = w_busy;
    assign done = w_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: a transaction-level timing/arithmetic
// model checks the WIDTH=8 instance every cycle; WIDTH=1 and WIDTH=32
// instances are checked per result.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, start, cin;
    logic [W-1:0] a, b, sum;
    logic         busy, done, cout;

    logic         s1, a1, b1, c1, busy1, done1, sum1, cout1;
    logic         s32, c32, busy32, done32, cout32;
    logic [31:0]  a32, b32, sum32;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .start(s1), .a(a1), .b(b1), .cin(c1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(s32), .a(a32), .b(b32), .cin(c32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    int           cyc = 0;
    bit           chk_en = 0;
    bit           m_act = 0;
    int           m_end = 0;
    logic [W:0]   m_res = '0;
    logic [W-1:0] e_sum = '0;
    logic         e_cout = 1'b0, e_busy = 1'b0, e_done = 1'b0;
    int           done_cnt = 0, busy_cnt = 0, last_done_cyc = 0;
    logic [W-1:0] last_sum = '0;
    logic         last_cout = 1'b0;

    always @(posedge clk) begin
        cyc++;
        // An accepted start at edge n yields busy after n..n+W-1, done after n+W
        if (reset) begin
            chk_en = 1;
            m_act  = 0;
            e_sum  = '0;
            e_cout = 1'b0;
        end else if (!m_act && start) begin
            m_act = 1;
            m_end = cyc + W;
            m_res = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        end
        e_busy = m_act && (cyc < m_end);
        e_done = m_act && (cyc == m_end);
        if (e_done) begin
            {e_cout, e_sum} = m_res;
            m_act = 0;
        end
        #1;
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(e_busy));
            chk("done", 64'(done), 64'(e_done));
            chk("sum",  64'(sum),  64'(e_sum));
            chk("cout", 64'(cout), 64'(e_cout));
        end
        if (done) begin
            done_cnt++;
            last_sum = sum;
            last_cout = cout;
            last_done_cyc = cyc;
        end
        if (busy) busy_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic go(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s timeout waiting for done", nm);
        end
    endtask

    initial begin
        int d1, dc, n;
        logic [63:0] exp;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        s1 = 0; a1 = 0; b1 = 0; c1 = 0;
        s32 = 0; a32 = '0; b32 = '0; c32 = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum",  64'(sum),  64'd0);
        chk("rst_cout", 64'(cout), 64'd0);

        // 0x5A + 0x33
        busy_cnt = 0; done_cnt = 0;
        go(8'h5A, 8'h33, 1'b0);
        wait_done("5a33");
        chk("5a33_sum", 64'(last_sum), 64'h8D);
        chk("5a33_cout", 64'(last_cout), 64'd0);
        chk("5a33_model", 64'({e_cout, e_sum}), 64'h08D);
        chk("5a33_busycyc", 64'(busy_cnt), 64'd8);
        chk("5a33_donecnt", 64'(done_cnt), 64'd1);

        // full carry chain
        go(8'hFF, 8'h01, 1'b0);
        wait_done("ff01");
        chk("ff01_sum", 64'(last_sum), 64'h00);
        chk("ff01_cout", 64'(last_cout), 64'd1);
        go(8'hFF, 8'hFF, 1'b1);
        wait_done("ffff1");
        chk("ffff1_sum", 64'(last_sum), 64'hFF);
        chk("ffff1_cout", 64'(last_cout), 64'd1);
        chk("ffff1_model", 64'({e_cout, e_sum}), 64'h1FF);

        // start during RUN is ignored; sum holds previous result until done
        go(8'h10, 8'h20, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'h77; b = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy", 64'(busy), 64'd1);
        chk("ign_hold_sum", 64'(sum), 64'hFF);
        wait_done("ign");
        chk("ign_sum", 64'(last_sum), 64'h30);
        chk("ign_cout", 64'(last_cout), 64'd0);

        // reset at RUN cycle 4 aborts
        go(8'hAA, 8'h55, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_sum",  64'(sum),  64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        dc = done_cnt;
        repeat (20) @(negedge clk);
        chk("abort_nodone", 64'(done_cnt), 64'(dc));

        // start held high: back-to-back additions
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        wait_done("b2b_1");
        d1 = last_done_cyc;
        chk("b2b1_sum", 64'(last_sum), 64'h02);
        chk("b2b1_cout", 64'(last_cout), 64'd0);
        a = 8'h80; b = 8'h80;
        @(negedge clk);
        wait_done("b2b_2");
        start = 1'b0;
        chk("b2b2_sum", 64'(last_sum), 64'h00);
        chk("b2b2_cout", 64'(last_cout), 64'd1);
        chk("b2b_gap", 64'(last_done_cyc - d1), 64'd9);

        // random operands on the WIDTH=8 instance
        for (int i = 0; i < 1000; i++) begin
            go(W'($urandom), W'($urandom), 1'($urandom));
            wait_done("rand8");
        end

        // WIDTH=1 instance
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom); s1 = 1'b1;
            @(negedge clk);
            s1 = 1'b0;
            n = 0;
            while (!done1 && n < 10) begin @(negedge clk); n++; end
            exp = 64'(a1) + 64'(b1) + 64'(c1);
            chk("w1_done", 64'(done1), 64'd1);
            chk("w1_res", 64'({cout1, sum1}), exp);
        end

        // WIDTH=32 instance
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            a32 = $urandom; b32 = $urandom; c32 = 1'($urandom); s32 = 1'b1;
            if (i == 0) begin a32 = 32'hFFFF_FFFF; b32 = 32'h1; c32 = 1'b0; end
            @(negedge clk);
            s32 = 1'b0;
            n = 0;
            while (!done32 && n < 50) begin @(negedge clk); n++; end
            exp = 64'(a32) + 64'(b32) + 64'(c32);
            chk("w32_done", 64'(done32), 64'd1);
            chk("w32_res", 64'({cout32, sum32}), exp);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
